// File: rtl/acorn_init_seq.sv
// rtl/acorn_init_seq.sv - ACORN-128 init sequencer: emits m_i, ca, cb for i = 0..1791, DW bits per beat
// Optional: ACORN_INIT_ZEROIZE_EN clears key/IV latches after each run and blanks m_out when not valid.
module acorn_init_seq #(
    parameter int DW    = 1,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic [KEY_W-1:0] iv_in,
    output logic [DW-1:0]    m_out,
    output logic [DW-1:0]    ca_out,
    output logic [DW-1:0]    cb_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);
    localparam int BEATS = 1792 / DW;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int LW    = $clog2(DW);
    localparam int IW    = CW + LW;

    generate
        if (!(DW == 1 || DW == 8 || DW == 32)) begin : g_bad_dw
            $error("acorn_init_seq: DW must be 1, 8 or 32");
        end
        if (KEY_W != 128) begin : g_bad_key_w
            $error("acorn_init_seq: KEY_W must be 128");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] iv_q;
    logic             accept;
    logic             last_beat;

    assign accept    = out_valid & out_ready;
    assign last_beat = (cnt == CW'(BEATS - 1));

    // DW divides 128, so a whole beat always comes from one 128-bit region (K, IV, or K again).
    function automatic logic [DW-1:0] beat_bits(
        input logic [KEY_W-1:0] key,
        input logic [KEY_W-1:0] iv,
        input logic [CW-1:0]    beat
    );
        logic [IW-1:0]    base;
        logic [KEY_W-1:0] word;
        logic [DW-1:0]    bits;
        base = IW'(beat) << LW;
        word = (base[IW-1:7] == (IW-7)'(1)) ? iv : key;
        bits = DW'(word >> base[6:0]);
        if (base == IW'(256)) begin
            bits[0] = ~bits[0];
        end
        return bits;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            key_q     <= '0;
            iv_q      <= '0;
            m_out     <= '0;
            ca_out    <= '0;
            cb_out    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_q     <= key_in;
                        iv_q      <= iv_in;
                        cnt       <= '0;
                        m_out     <= beat_bits(key_in, iv_in, '0);
                        ca_out    <= '1;
                        cb_out    <= '1;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (last_beat) begin
                            ca_out    <= '0;
                            cb_out    <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
`ifdef ACORN_INIT_ZEROIZE_EN
                            m_out     <= '0;
`endif
                        end else begin
                            cnt   <= cnt + CW'(1);
                            m_out <= beat_bits(key_q, iv_q, cnt + CW'(1));
                        end
                    end
                end
                S_DONE: begin
`ifdef ACORN_INIT_ZEROIZE_EN
                    key_q <= '0;
                    iv_q  <= '0;
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/acorn_init_seq.md
Name: acorn_init_seq

Overview:
- Parametrised ACORN-128 initialization sequencer.
- Owns its own step counter and emits DW consecutive message bits m_i per beat, plus the ca/cb control vectors, for i = 0..1791.
- Uses a start/busy/done and valid/ready handshake.
- Sits between the key/IV register file and the DW-wide ACORN state-update core; replaces the externally counted bit-serial init block.

Parameters:
DW, 1, message bits per beat; legal values 1, 8, 32; any other value is a compile-time error.
KEY_W, 128, key and IV width; fixed at 128 for ACORN-128.
(local) BEATS = 1792/DW; CW = $clog2(BEATS+1).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
key_in  in  128  key K; latched on accepted start
iv_in  in  128  IV; latched on accepted start
m_out  out  DW  m_out[j] = m_{i+j}, i = beat*DW
ca_out  out  DW  all ones while valid, else zero
cb_out  out  DW  all ones while valid, else zero
out_valid  out  1  beat on m_out/ca_out/cb_out is valid
out_ready  in  1  core accepts beat when out_valid & out_ready
busy  out  1  high from accepted start through the last accepted beat
done  out  1  one-cycle pulse in the cycle after the last beat is accepted

Behaviour:
- Reset (async, any time, including mid-run): state=IDLE, beat counter=0, key/IV latches=0. All outputs 0: m_out, ca_out, cb_out, out_valid, busy, done.
- Message definition, per bit index i:
  - i = 0..127: m_i = K[i]
  - i = 128..255: m_i = IV[i-128]
  - i = 256: m_i = K[0] ^ 1
  - i = 257..1791: m_i = K[i mod 128]
- States:
  - IDLE: out_valid=0. On start=1, latch key/IV, set counter=0, go RUN. busy rises in the following cycle.
  - RUN: out_valid=1. m_out is driven registered from the counter and the latches.
    - Handshake when out_valid & out_ready: counter increments.
    - When out_ready=0: counter and all outputs hold, with no glitch or advance.
    - Beat at counter = BEATS-1 accepted: go DONE.
  - DONE: one cycle. done=1, busy=0, out_valid=0. Then go IDLE.
- Latency:
  - First beat: valid in the cycle after start, i.e. 1-cycle start-to-valid.
  - Full run with out_ready tied high: BEATS cycles of valid, then done. Runs are 1792, 224 and 56 beats for DW = 1, 8, 32.
- Start is ignored when not in IDLE, including during DONE. Back-to-back: start asserted in the cycle done is high is ignored; start in the next cycle (IDLE) is accepted.
- Width and boundary rules:
  - Because DW divides 128, a beat never straddles the key/IV or IV/flip boundaries.
  - For DW>1, the flip bit i=256 is lane 0 of beat 256/DW, and the remaining lanes of that beat carry K[j].
  - Index arithmetic uses CW+log2(DW) bits; no wrap past 1791.
- key_in/iv_in changes after start are ignored until the next accepted start.

Optional Feature:
- Macro ACORN_INIT_ZEROIZE_EN.
- Defined:
  - In the DONE cycle, the key and IV latches are cleared to 0.
  - A start accepted at any point clears the latches before reloading.
  - m_out is forced to 0 whenever out_valid=0, so no key material lingers.
- Not defined:
  - Latches retain the last key/IV until the next start or reset.
  - m_out holds its last value when out_valid=0.

Test Plan:
- DW=1, K=128'h0, IV=128'h0, ready=1 -> m_out=0 for beats 0..255; beat 256 m_out=1; beats 257..1791 m_out=0; done at cycle 1793 after start; ca/cb=1 throughout.
- DW=8, K=128'h0123456789ABCDEF_FEDCBA9876543210, IV=all ones -> 224 beats:
  - beat 0 m_out=K[7:0]=8'h10;
  - beats 16..31 m_out=8'hFF;
  - beat 32 m_out=K[7:0]^8'h01=8'h11;
  - beat 48 m_out=8'h10.
- DW=32, out_ready toggled 1,0,0,1 pattern -> m_out/counter frozen while ready=0; exactly 56 accepted beats; done one cycle after the 56th.
- start re-asserted during RUN and during DONE with new key -> ignored; sequence matches the original key; next start in IDLE uses the new key.
- rst pulsed at beat 100 -> same cycle out_valid=0, busy=0, m_out=0; after release, IDLE until start.
- ACORN_INIT_ZEROIZE_EN defined, run to completion -> internal key/IV latches read 0 the cycle after done; m_out=0 while idle.
